// File: rtl/mainmenu_index_gen_pkg.sv
// Shared types and constants for the main-menu pixel-index stage.
// Holds the image geometry, palette indices and the selection-FSM state type.
package mainmenu_pkg;

   typedef enum logic [1:0] {MENU, CONFIRM, DONE} menu_state_t;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam int IMG_W    = 320;
   localparam int IMG_H    = 240;

   localparam logic [3:0] TEXT_IDX   = 4'h3;
   localparam logic [3:0] HILITE_IDX = 4'h2;

   // Address of the stored 320x240 image for a 2x-upscaled screen pixel; y*320 = (y<<8)+(y<<6).
   function automatic logic [16:0] img_addr(input logic [9:0] x, input logic [9:0] y);
      logic [16:0] xx;
      logic [16:0] yy;
      xx = {8'd0, x[9:1]};
      yy = {8'd0, y[9:1]};
      return (yy << 8) + (yy << 6) + xx;
   endfunction

endpackage

// File: rtl/mainmenu_index_gen_if.sv
// Scan/ROM/palette bus of the main-menu index stage.
// There is no valid/ready pair: the stream advances every pixel clock with no backpressure.
interface mainmenu_index_gen_if;

   logic [9:0]  DrawX;
   logic [9:0]  DrawY;
   logic        blank;
   logic        hs_in;
   logic        vs_in;
   logic [16:0] rom_addr;
   logic [3:0]  rom_q;
   logic [3:0]  index;
   logic        blank_out;
   logic        hs_out;
   logic        vs_out;

   modport master (
      output DrawX, DrawY, blank, hs_in, vs_in, rom_q,
      input  rom_addr, index, blank_out, hs_out, vs_out
   );

   modport slave (
      input  DrawX, DrawY, blank, hs_in, vs_in, rom_q,
      output rom_addr, index, blank_out, hs_out, vs_out
   );

endinterface

// File: rtl/mainmenu_index_gen_menu_sel_fsm.sv
// Menu selection FSM: collects key presses per frame, steps sel once per frame
// start with wrap-around, and pulses start when the selection is confirmed.
module menu_sel_fsm
   import mainmenu_pkg::*;
#(
   parameter int NUM_ITEMS = 3
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        key_up,
   input  logic        key_down,
   input  logic        key_enter,
   input  logic        frame_start,
   input  logic        menu_en,
   output logic [1:0]  sel,
   output logic        start,
   output menu_state_t state
);

   localparam logic [1:0] LAST = 2'(NUM_ITEMS - 1);

   logic up_pend;
   logic dn_pend;
   logic en_prev;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state   <= MENU;
         sel     <= 2'd0;
         start   <= 1'b0;
         up_pend <= 1'b0;
         dn_pend <= 1'b0;
         en_prev <= 1'b0;
      end else begin
         start   <= 1'b0;
         en_prev <= menu_en;
         case (state)
            MENU: begin
               if (!menu_en) begin
                  up_pend <= 1'b0;
                  dn_pend <= 1'b0;
               end else begin
                  // Opposing presses in one frame cancel out.
                  if (frame_start) begin
                     if (up_pend && !dn_pend)
                        sel <= (sel == 2'd0) ? LAST : sel - 2'd1;
                     else if (dn_pend && !up_pend)
                        sel <= (sel == LAST) ? 2'd0 : sel + 2'd1;
                     up_pend <= 1'b0;
                     dn_pend <= 1'b0;
                  end else begin
                     if (key_up)   up_pend <= 1'b1;
                     if (key_down) dn_pend <= 1'b1;
                  end
                  if (key_enter) begin
                     state   <= CONFIRM;
                     start   <= 1'b1;
                     up_pend <= 1'b0;
                     dn_pend <= 1'b0;
                  end
               end
            end
            CONFIRM: state <= DONE;
            DONE: begin
               if (menu_en && !en_prev) begin
                  state   <= MENU;
                  up_pend <= 1'b0;
                  dn_pend <= 1'b0;
               end
            end
            default: state <= MENU;
         endcase
      end
   end

endmodule

// File: rtl/mainmenu_index_gen.sv
// Two-stage pixel-index pipeline for the main menu: scan coords -> ROM address,
// ROM data -> palette index with the selected item's text recoloured.
module mainmenu_index_gen
   import mainmenu_pkg::*;
#(
   parameter int NUM_ITEMS = 3,
   parameter int ITEM_Y0   = 120,
   parameter int ITEM_H    = 64
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 key_up,
   input  logic                 key_down,
   input  logic                 key_enter,
   input  logic                 menu_en,
   mainmenu_index_gen_if.slave  vga,
   output logic [1:0]           sel,
   output logic                 start,
   output menu_state_t          state_dbg
);

   localparam logic [9:0] SCR_W  = 10'(SCREEN_W);
   localparam logic [9:0] SCR_H  = 10'(SCREEN_H);
   localparam logic [9:0] BAND_0 = 10'(ITEM_Y0);
   localparam logic [9:0] BAND_H = 10'(ITEM_H);

   logic       s1_valid;
   logic [9:0] s1_row;
   logic       blank_d1;
   logic       hs_d1;
   logic       vs_d1;
   logic       vs_prev;
   logic       in_range;
   logic       frame_start;
   logic [9:0] band_lo;
   logic [9:0] band_hi;
   logic       in_band;

   assign in_range    = (vga.DrawX < SCR_W) && (vga.DrawY < SCR_H) && vga.blank;
   assign frame_start = vs_prev && !vga.vs_in;

   // Band test uses the row that produced the ROM word now on rom_q.
   assign band_lo = BAND_0 + BAND_H * {8'd0, sel};
   assign band_hi = band_lo + BAND_H;
   assign in_band = (s1_row >= band_lo) && (s1_row < band_hi);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         vga.rom_addr  <= 17'd0;
         s1_valid      <= 1'b0;
         s1_row        <= 10'd0;
         blank_d1      <= 1'b0;
         hs_d1         <= 1'b1;
         vs_d1         <= 1'b1;
         vs_prev       <= 1'b1;
         vga.index     <= 4'd0;
         vga.blank_out <= 1'b0;
         vga.hs_out    <= 1'b1;
         vga.vs_out    <= 1'b1;
      end else begin
         if (in_range) begin
            vga.rom_addr <= img_addr(vga.DrawX, vga.DrawY);
            s1_valid     <= 1'b1;
         end else begin
            vga.rom_addr <= 17'd0;
            s1_valid     <= 1'b0;
         end
         s1_row   <= vga.DrawY;
         blank_d1 <= vga.blank;
         hs_d1    <= vga.hs_in;
         vs_d1    <= vga.vs_in;
         vs_prev  <= vga.vs_in;

         if (!s1_valid)
            vga.index <= 4'd0;
         else if (vga.rom_q == TEXT_IDX && in_band)
            vga.index <= HILITE_IDX;
         else
            vga.index <= vga.rom_q;
         vga.blank_out <= blank_d1;
         vga.hs_out    <= hs_d1;
         vga.vs_out    <= vs_d1;
      end
   end

   menu_sel_fsm #(.NUM_ITEMS(NUM_ITEMS)) u_sel_fsm (
      .Clk         (Clk),
      .Reset       (Reset),
      .key_up      (key_up),
      .key_down    (key_down),
      .key_enter   (key_enter),
      .frame_start (frame_start),
      .menu_en     (menu_en),
      .sel         (sel),
      .start       (start),
      .state       (state_dbg)
   );

endmodule

// File: tb/tb_mainmenu_index_gen.sv
// Directed bench for mainmenu_index_gen: address/latency, blanking, sync delay,
// selection wrap and debounce, highlight band edges, confirm and reset flush.
module tb_mainmenu_index_gen;
   import mainmenu_pkg::*;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        key_up, key_down, key_enter, menu_en;
   logic [1:0]  sel;
   logic        start;
   menu_state_t state_dbg;

   logic        rom_ovr;
   logic [3:0]  rom_force;

   int checks = 0;
   int errors = 0;

   mainmenu_index_gen_if vga ();

   mainmenu_index_gen dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .key_up    (key_up),
      .key_down  (key_down),
      .key_enter (key_enter),
      .menu_en   (menu_en),
      .vga       (vga),
      .sel       (sel),
      .start     (start),
      .state_dbg (state_dbg)
   );

   // ---------------- clock ----------------
   always #5 Clk = ~Clk;

   // ROM model: data for the registered address is ready by the next edge.
   always_comb vga.rom_q = rom_ovr ? rom_force : vga.rom_addr[3:0];

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_up();
      key_up = 1'b1; tick(); key_up = 1'b0;
   endtask

   task automatic pulse_down();
      key_down = 1'b1; tick(); key_down = 1'b0;
   endtask

   task automatic frame();
      vga.vs_in = 1'b0; tick();
      vga.vs_in = 1'b1; tick();
   endtask

   // ---------------- stimulus ----------------
   logic [7:0] bp, hp, vp;
   logic [9:0] rows [7];
   logic [3:0] frc  [7];
   logic [3:0] expi [7];

   initial begin
      Reset = 1'b1; key_up = 1'b0; key_down = 1'b0; key_enter = 1'b0; menu_en = 1'b1;
      vga.DrawX = 10'd0; vga.DrawY = 10'd0; vga.blank = 1'b0;
      vga.hs_in = 1'b1; vga.vs_in = 1'b1;
      rom_ovr = 1'b0; rom_force = 4'd0;
      repeat (3) tick();

      check("rst_rom_addr",  32'(vga.rom_addr), 32'd0);
      check("rst_index",     32'(vga.index), 32'd0);
      check("rst_blank_out", 32'(vga.blank_out), 32'd0);
      check("rst_hs_out",    32'(vga.hs_out), 32'd1);
      check("rst_vs_out",    32'(vga.vs_out), 32'd1);
      check("rst_sel",       32'(sel), 32'd0);
      check("rst_start",     32'(start), 32'd0);
      check("rst_state",     32'(state_dbg), 32'(MENU));
      Reset = 1'b0;
      tick();

      // Address and 2-cycle latency: (3>>1)*320 + (5>>1) = 322 = 0x142.
      vga.DrawX = 10'd5; vga.DrawY = 10'd3; vga.blank = 1'b1;
      tick();
      check("addr_322", 32'(vga.rom_addr), 32'd322);
      vga.DrawX = 10'd700;
      tick();
      check("lat_index", 32'(vga.index), 32'h2);
      check("oob_addr",  32'(vga.rom_addr), 32'd0);
      rom_ovr = 1'b1; rom_force = 4'h5;
      tick();
      check("oob_x_index", 32'(vga.index), 32'd0);
      vga.DrawX = 10'd10; vga.DrawY = 10'd10; vga.blank = 1'b0;
      tick();
      tick();
      check("blank_index", 32'(vga.index), 32'd0);
      vga.DrawX = 10'd10; vga.DrawY = 10'd500; vga.blank = 1'b1;
      tick();
      tick();
      check("oob_y_index", 32'(vga.index), 32'd0);

      // blank/hs/vs delay: output after edge k equals input applied before edge k-1.
      bp = 8'b0100_1101; hp = 8'b1001_0110; vp = 8'b1101_1011;
      for (int k = 0; k <= 8; k++) begin
         if (k < 8) begin
            vga.blank = bp[k]; vga.hs_in = hp[k]; vga.vs_in = vp[k];
         end
         tick();
         if (k >= 1) begin
            check("dly_blank", 32'(vga.blank_out), 32'(bp[k-1]));
            check("dly_hs",    32'(vga.hs_out),    32'(hp[k-1]));
            check("dly_vs",    32'(vga.vs_out),    32'(vp[k-1]));
         end
      end
      vga.vs_in = 1'b1; vga.hs_in = 1'b1; vga.blank = 1'b1;
      tick();

      // Keys ignored while the menu is not shown.
      menu_en = 1'b0;
      pulse_down();
      menu_en = 1'b1;
      frame();
      check("menu_off_sel", 32'(sel), 32'd0);

      // Wrap up from 0, then step down through 0,1,2.
      pulse_up();
      frame();
      check("wrap_up_sel", 32'(sel), 32'd2);
      pulse_down(); frame();
      check("down_sel_0", 32'(sel), 32'd0);
      pulse_down(); frame();
      check("down_sel_1", 32'(sel), 32'd1);
      pulse_down(); frame();
      check("down_sel_2", 32'(sel), 32'd2);

      // Several presses in one frame give one step; opposing presses cancel.
      pulse_down(); pulse_down(); pulse_down();
      frame();
      check("debounce_sel", 32'(sel), 32'd0);
      pulse_up(); pulse_down();
      frame();
      check("cancel_sel", 32'(sel), 32'd0);
      pulse_down(); frame();
      check("hl_sel_1", 32'(sel), 32'd1);

      // Highlight band for sel=1 is rows [184,248).
      rows[0] = 10'd190; frc[0] = 4'h3; expi[0] = 4'h2;
      rows[1] = 10'd130; frc[1] = 4'h3; expi[1] = 4'h3;
      rows[2] = 10'd190; frc[2] = 4'h4; expi[2] = 4'h4;
      rows[3] = 10'd184; frc[3] = 4'h3; expi[3] = 4'h2;
      rows[4] = 10'd183; frc[4] = 4'h3; expi[4] = 4'h3;
      rows[5] = 10'd247; frc[5] = 4'h3; expi[5] = 4'h2;
      rows[6] = 10'd248; frc[6] = 4'h3; expi[6] = 4'h3;
      vga.DrawX = 10'd100; vga.blank = 1'b1;
      for (int k = 0; k <= 7; k++) begin
         if (k < 7) vga.DrawY = rows[k];
         if (k >= 1) rom_force = frc[k-1];
         tick();
         if (k >= 1) check("hl_index", 32'(vga.index), 32'(expi[k-1]));
      end
      rom_ovr = 1'b0;

      // Confirm: one-cycle start, keys ignored in DONE, menu_en edge re-arms.
      key_enter = 1'b1; tick(); key_enter = 1'b0;
      check("cfm_start_hi", 32'(start), 32'd1);
      check("cfm_state",    32'(state_dbg), 32'(CONFIRM));
      tick();
      check("cfm_start_lo", 32'(start), 32'd0);
      check("done_state",   32'(state_dbg), 32'(DONE));
      pulse_down(); frame();
      check("done_sel_hold", 32'(sel), 32'd1);
      check("done_no_start", 32'(start), 32'd0);
      menu_en = 1'b0; tick();
      menu_en = 1'b1; tick();
      check("rearm_state", 32'(state_dbg), 32'(MENU));
      pulse_down(); frame();
      check("rearm_sel", 32'(sel), 32'd2);

      // Reset mid-stream flushes both stages.
      vga.DrawX = 10'd5; vga.DrawY = 10'd3; vga.blank = 1'b1;
      tick(); tick();
      check("pre_rst_index", 32'(vga.index), 32'h2);
      Reset = 1'b1; tick(); Reset = 1'b0;
      check("flush_index_0", 32'(vga.index), 32'd0);
      check("flush_sel",     32'(sel), 32'd0);
      tick();
      check("flush_index_1", 32'(vga.index), 32'd0);
      tick();
      check("refill_index", 32'(vga.index), 32'h2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mainmenu_index_gen.md
Name: mainmenu_index_gen

Overview:
- Pixel-index stage directly upstream of the main-menu palette.
- Converts VGA scan coordinates into addresses for the 4-bit-per-pixel main-menu image ROM, stored at 320x240 and shown 2x upscaled.
- Aligns the ROM data with delayed blank/sync signals.
- Runs the menu-selection FSM, which recolours the selected item's text before the 4-bit index goes to the palette.

Parameters:
- IMG_W, 320, stored image width in pixels.
- IMG_H, 240, stored image height in pixels.
- NUM_ITEMS, 3, number of selectable menu items.
- ITEM_Y0, 120, first screen row of item 0.
- ITEM_H, 64, screen-row height of each item band.
- TEXT_IDX, 4'h3, palette index of menu text (white).
- HILITE_IDX, 4'h2, palette index used for highlight (orange).

Ports:
- Clk  in  1  pixel clock.
- Reset  in  1  synchronous, active-high.
- DrawX  in  10  current scan column, 0..799.
- DrawY  in  10  current scan row, 0..524.
- blank  in  1  active-low blanking from the VGA controller.
- hs_in  in  1  hsync from the VGA controller.
- vs_in  in  1  vsync from the VGA controller, active-low.
- key_up  in  1  one-cycle press pulse.
- key_down  in  1  one-cycle press pulse.
- key_enter  in  1  one-cycle press pulse.
- menu_en  in  1  level; high while the game is showing the menu.
- rom_addr  out  17  image ROM read address.
- rom_q  in  4  ROM data; valid 1 cycle after rom_addr is registered.
- index  out  4  palette index to the palette stage.
- blank_out  out  1  blank delayed to match index.
- hs_out  out  1  hsync delayed to match index.
- vs_out  out  1  vsync delayed to match index.
- sel  out  2  currently selected item.
- start  out  1  one-cycle pulse on confirm.

Behaviour:
Reset values:
- rom_addr=0, index=0, blank_out=0, hs_out=1, vs_out=1, sel=0, start=0.
- FSM in MENU; all pending flags cleared; both pipeline stages cleared.

Pipeline (latency 2 cycles from DrawX/DrawY to index):
- S1: addr = (DrawY>>1)*IMG_W + (DrawX>>1).
  - Multiply done as shift-add, (y<<8)+(y<<6), 17-bit.
  - Registered to rom_addr.
  - If DrawX>=640, DrawY>=480, or blank=0: rom_addr=0 and the S1 valid bit is cleared.
- S2: rom_q arrives. index is registered as:
  - 0 if S1 not valid;
  - else HILITE_IDX if rom_q==TEXT_IDX and the S1 row lies in [ITEM_Y0+sel*ITEM_H, ITEM_Y0+(sel+1)*ITEM_H);
  - else rom_q.
- blank, hs_in and vs_in each pass through the same 2-flop delay.
- The S1 row used for the band compare is carried through the pipeline, not re-read from DrawY.

Selection FSM:
- States: MENU, CONFIRM, DONE.
- MENU:
  - key_up sets up_pend; key_down sets dn_pend.
  - On the vs_in falling edge (frame start):
    - only up_pend: sel = (sel==0) ? NUM_ITEMS-1 : sel-1;
    - only dn_pend: sel = (sel==NUM_ITEMS-1) ? 0 : sel+1;
    - both pending: sel unchanged;
    - both pending flags cleared in every case.
  - At most one step per frame regardless of press count.
  - key_enter -> CONFIRM. Pending flags are cleared, and sel is frozen at its current value.
- CONFIRM: start=1 for exactly this cycle -> DONE.
- DONE:
  - keys ignored; sel held; highlight still drawn.
  - menu_en rising edge (registered compare) -> MENU with pending flags cleared.
- menu_en low in MENU: keys ignored, pending flags cleared.
- key_enter in the same cycle as a frame-start update: the update is applied first, then the FSM goes to CONFIRM, so start is reported against the new sel.
- Reset mid-frame: the pipeline flushes, so the next 2 index values are 0 until the pipeline refills.

Decomposition:
- Package mainmenu_pkg:
  - typedef enum menu_state_t {MENU, CONFIRM, DONE};
  - constants SCREEN_W=640, SCREEN_H=480, IMG_W, IMG_H, TEXT_IDX, HILITE_IDX.
- One sub-module, menu_sel_fsm:
  - contains the FSM, pending flags and sel wrap;
  - inputs: keys, frame-start strobe, menu_en;
  - outputs: sel, start.
- The top level holds the address/delay pipeline and the band compare.

Test Plan:
- Address/latency:
  - Stimulus: DrawX=5, DrawY=3, blank=1; ROM model with 1-cycle latency returning addr[3:0].
  - Required: rom_addr=322 one cycle later; index=4'h2 two cycles later.
- Blank/out-of-range:
  - Stimulus: DrawX=700, or blank=0 with ROM returning 4'h5.
  - Required: index=0 two cycles later; blank_out, hs_out and vs_out equal the inputs delayed by exactly 2 cycles.
- Wrap:
  - Stimulus: from reset, key_up pulse, then one frame start.
  - Required: sel=2. Then 3x (key_down + frame start) -> sel sequence 0,1,2.
- Debounce/simultaneous:
  - Stimulus: 3 key_down pulses in one frame -> sel advances by 1 only.
  - Stimulus: key_up and key_down in the same frame -> sel unchanged.
- Highlight:
  - Stimulus: sel=1; ROM returns 4'h3 at DrawY=190, then at DrawY=130.
  - Required: index=4'h2 for row 190; index=4'h3 for row 130; ROM value 4'h4 passes through unchanged.
- Confirm:
  - Stimulus: key_enter.
  - Required: start high exactly 1 cycle. Subsequent keys leave sel unchanged. A menu_en 0->1 transition returns the FSM to MENU, and key_down then works again.
